// File: rtl/yarvi_fq.sv
// yarvi_fq -- fetch queue between the YARVI fetch stage (FE) and the
// register-read stage (RF). A circular valid/ready FIFO of DEPTH {pc, insn}
// entries. FE can run ahead while RF/EX are stalled, and a restart flushes
// every queued instruction in a single cycle.
//
// Optional feature: define YARVI_FQ_BYPASS_EN to forward an input straight
// to the output (zero latency) while the queue is empty.
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high
//   restart    in   EX redirect; flush queue this cycle
//   in_valid   in   FE presents an instruction
//   in_ready   out  queue accepts this cycle (!full && !reset)
//   in_pc      in   PC of presented instruction   [PCW]
//   in_insn    in   presented instruction         [ILEN]
//   out_valid  out  head entry valid toward RF
//   out_ready  in   RF consumes head this cycle
//   out_pc     out  PC of head entry              [PCW]
//   out_insn   out  head instruction              [ILEN]
//   count      out  current occupancy             [$clog2(DEPTH)+1]
module yarvi_fq #(
  parameter int PCW   = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PCW-1:0]           in_pc,
  input  logic [ILEN-1:0]          in_insn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PCW-1:0]           out_pc,
  output logic [ILEN-1:0]          out_insn,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PCW-1:0]  r_pc_mem   [DEPTH];
  logic [ILEN-1:0] r_insn_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;      // input forwarded to output this cycle
  logic w_bypass_take; // forwarded input consumed without being stored
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign in_ready = !w_full && !reset;

`ifdef YARVI_FQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !restart && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_bypass_take = w_bypass && out_ready;

  // A bypassed entry that RF takes immediately never occupies a slot.
  assign w_push = in_valid && in_ready && !restart && !w_bypass_take;
  assign w_pop  = !w_empty && out_ready && !restart && !reset;

  assign out_valid = !reset && (!w_empty || w_bypass);
  assign count     = r_count;

  always_comb begin
    out_pc   = '0;
    out_insn = '0;
    if (!reset) begin
      if (!w_empty) begin
        out_pc   = r_pc_mem[r_rd_ptr];
        out_insn = r_insn_mem[r_rd_ptr];
      end else if (w_bypass) begin
        out_pc   = in_pc;
        out_insn = in_insn;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_insn_mem[r_wr_ptr] <= in_insn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (restart) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_yarvi_fq.sv
module tb_yarvi_fq;

  localparam int PCW   = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic             clock;
  logic             reset;
  logic             restart;
  logic             in_valid;
  logic             in_ready;
  logic [PCW-1:0]   in_pc;
  logic [ILEN-1:0]  in_insn;
  logic             out_valid;
  logic             out_ready;
  logic [PCW-1:0]   out_pc;
  logic [ILEN-1:0]  out_insn;
  logic [$clog2(DEPTH):0] count;

  yarvi_fq #(.PCW(PCW), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .restart  (restart),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_insn  (in_insn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_insn (out_insn),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

`ifdef YARVI_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one input beat; 'accepted' states whether this beat will be taken.
  task automatic offer(input logic v, input logic [31:0] pc, input bit accepted);
    exp_t e;
    in_valid = v;
    in_pc    = pc;
    in_insn  = insn_of(pc);
    if (v && accepted) begin
      e.pc = pc; e.insn = insn_of(pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares every consumed output against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && !restart && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc_order", out_pc, e.pc);
        chk("out_insn_order", out_insn, e.insn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; out_ready = 1'b0;
    offer(1'b0, 32'h0, 1'b0);

    // Reset held for two cycles
    cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Fill with out_ready low
    for (int unsigned i = 0; i < 4; i++) begin
      offer(1'b1, 32'h100 + 4 * i, 1'b1);
      cyc();
    end
    offer(1'b0, 32'h0, 1'b0);
    #1;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_head_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    cyc();
    chk("first_pop_in_ready", 32'(in_ready), 32'd1);
    chk("first_pop_count", 32'(count), 32'd3);
    for (int unsigned i = 0; i < 3; i++) cyc();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Streaming 20 cycles, pointers wrap several times
    for (int unsigned i = 0; i < 20; i++) begin
      offer(1'b1, 32'(4 * i), 1'b1);
      cyc();
      chk("stream_count", 32'(count), BYP ? 32'd0 : 32'd1);
    end
    offer(1'b0, 32'h0, 1'b0);
    cyc();
    chk("stream_end_count", 32'(count), 32'd0);

    // Restart flush with a simultaneous input that must be dropped
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      offer(1'b1, 32'h300 + 4 * i, 1'b1);
      cyc();
    end
    chk("pre_restart_count", 32'(count), 32'd3);
    restart = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 32'h200, 1'b0);
    exp_q.delete();
    cyc();
    restart = 1'b0;
    offer(1'b0, 32'h0, 1'b0);
    #1;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_out_valid", 32'(out_valid), 32'd0);
    for (int unsigned i = 0; i < 3; i++) cyc();
    chk("restart_after_count", 32'(count), 32'd0);

    // Back-pressure: head 0x40 held for 5 cycles while pushing behind it
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      offer(i < 4, 32'h40 + 4 * i, 1'b1);
      cyc();
      chk("bp_out_pc", out_pc, 32'h40);
      chk("bp_out_insn", out_insn, insn_of(32'h40));
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    chk("bp_count", 32'(count), 32'd4);
    offer(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) cyc();
    chk("bp_drain_count", 32'(count), 32'd0);

    // Bypass / latency on empty queue
    offer(1'b1, 32'h80, 1'b1);
    #1;
    chk("byp_same_cycle_valid", 32'(out_valid), BYP ? 32'd1 : 32'd0);
    chk("byp_same_cycle_pc", out_pc, BYP ? 32'h80 : 32'h0);
    cyc();
    offer(1'b0, 32'h0, 1'b0);
    #1;
    chk("byp_next_valid", 32'(out_valid), BYP ? 32'd0 : 32'd1);
    chk("byp_next_count", 32'(count), BYP ? 32'd0 : 32'd1);
    chk("byp_next_pc", out_pc, BYP ? 32'h0 : 32'h80);
    cyc();
    chk("byp_end_count", 32'(count), 32'd0);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      offer(1'b1, 32'h500 + 4 * i, 1'b1);
      cyc();
    end
    offer(1'b0, 32'h0, 1'b0);
    chk("mid_pre_count", 32'(count), 32'd3);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_pc", out_pc, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_post_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("mid_post_out_valid", 32'(out_valid), 32'd0);
    chk("mid_post_count", 32'(count), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
